fb_plot_sink: RTL and testbench

- Receiving end of the plot interface: accepts (x, y, colour) pixel writes from the square-drawing datapath/FSM and commits them to a 160x120, 3-bit on-chip frame buffer write port.
- Absorbs short bursts in a small FIFO and computes the linear address.
- Drops off-screen pixels.
- Provides a full-screen clear sweep.
- Sits between the drawing datapath and the frame buffer RAM that the VGA scan-out reads.

---
 rtl/fb_pkg.sv | 37 +++
 rtl/fb_fifo.sv | 48 ++++
 rtl/fb_plot_sink.sv | 138 +++++++++++++
 tb/tb_fb_plot_sink.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and screen constants for the plot sink: screen geometry, FSM
// states, the queued pixel record and the linear-address helper.
package fb_pkg;

    localparam int SCR_W    = 160;
    localparam int SCR_H    = 120;
    localparam int ADDR_W   = 15;
    localparam int COLOUR_W = 3;

    localparam logic [7:0]        X_LIM     = 8'(SCR_W);
    localparam logic [6:0]        Y_LIM     = 7'(SCR_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCR_W * SCR_H - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR
    } state_t;

    typedef struct packed {
        logic [7:0]          x;
        logic [6:0]          y;
        logic [COLOUR_W-1:0] c;
    } pixel_t;

    // y*160 + x as two shifts and adds, kept at full address width.
    function automatic logic [ADDR_W-1:0] pix_addr(input pixel_t p);
        logic [ADDR_W-1:0] y_ext;
        y_ext = ADDR_W'(p.y);
        return (y_ext << 7) + (y_ext << 5) + ADDR_W'(p.x);
    endfunction

    function automatic logic on_screen(input pixel_t p);
        return (p.x < X_LIM) && (p.y < Y_LIM);
    endfunction

endpackage

// File: rtl/fb_fifo.sv
// Small synchronous FIFO of pixel records buffering plot bursts ahead of the
// frame buffer write port. Wrap-bit pointers give full/empty/count.
module fb_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     r_set,
    input  logic                     push,
    input  pixel_t                   wdata,
    input  logic                     pop,
    output pixel_t                   rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    pixel_t        mem [DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;

    // NOTE: the storage array is deliberately not reset; only the pointers
    // define what is valid, and a reset on the array would force it into flops.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge r_set) begin
        if (r_set) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));
    assign rdata = mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/fb_plot_sink.sv
// Plot-interface sink: queues pixel writes, drops off-screen ones, runs a
// full-screen clear sweep. Optional drop counter enabled by FB_OOB_COUNT_EN.
module fb_plot_sink
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                r_set,
    input  logic [7:0]          plot_x,
    input  logic [6:0]          plot_y,
    input  logic [COLOUR_W-1:0] plot_c,
    input  logic                plot_valid,
    output logic                plot_ready,
    input  logic                clear_req,
    input  logic [COLOUR_W-1:0] clear_colour,
    output logic                busy,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [COLOUR_W-1:0] mem_data
`ifdef FB_OOB_COUNT_EN
    ,
    output logic [7:0]          oob_count
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t              state;
    logic                clear_pending;
    logic [COLOUR_W-1:0] fill_colour;
    logic [ADDR_W-1:0]   clr_addr;

    pixel_t              fifo_wdata;
    pixel_t              fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;

    logic push;
    logic pop;
    logic clr_take;
    logic pend_next;
    logic drained;

    assign plot_ready = !fifo_full && !clear_pending && (state != CLEAR);
    assign busy       = (state != IDLE) || clear_pending;

    assign fifo_wdata = '{x: plot_x, y: plot_y, c: plot_c};
    assign push       = plot_valid && plot_ready;
    assign pop        = (state == DRAIN) && !fifo_empty;
    assign clr_take   = clear_req && (state != CLEAR);
    assign pend_next  = clear_pending || clr_take;
    // FIFO will be empty after this edge and nothing new arrives.
    assign drained    = !push && (fifo_empty || (pop && fifo_count == CNT_W'(1)));

    fb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .r_set (r_set),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // NOTE: all state here is updated with non-blocking assignments so every
    // branch reads the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge r_set) begin
        if (r_set) begin
            state         <= IDLE;
            clear_pending <= 1'b0;
            fill_colour   <= '0;
            clr_addr      <= '0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_data      <= '0;
        end else begin
            mem_we <= 1'b0;
            if (clr_take) fill_colour <= clear_colour;

            case (state)
                IDLE: begin
                    if (push) begin
                        state         <= DRAIN;
                        clear_pending <= clr_take;
                    end else if (clr_take) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                    end
                end

                DRAIN: begin
                    if (pop) begin
                        mem_we   <= on_screen(fifo_rdata);
                        mem_addr <= pix_addr(fifo_rdata);
                        mem_data <= fifo_rdata.c;
                    end
                    if (drained) begin
                        clear_pending <= 1'b0;
                        if (pend_next) begin
                            state    <= CLEAR;
                            clr_addr <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        clear_pending <= pend_next;
                    end
                end

                CLEAR: begin
                    mem_we   <= 1'b1;
                    mem_addr <= clr_addr;
                    mem_data <= fill_colour;
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == LAST_ADDR) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef FB_OOB_COUNT_EN
    // Saturating count of popped pixels that fell outside the screen.
    always_ff @(posedge clk or posedge r_set) begin
        if (r_set) begin
            oob_count <= '0;
        end else if (pop && !on_screen(fifo_rdata) && oob_count != 8'hFF) begin
            oob_count <= oob_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fb_plot_sink.sv
// Self-checking bench for fb_plot_sink: directed steps plus random plots,
// checked against a queue of expected frame-buffer writes.
module tb_fb_plot_sink;

    logic       clk = 1'b0;
    logic       r_set;
    logic [7:0] plot_x;
    logic [6:0] plot_y;
    logic [2:0] plot_c;
    logic       plot_valid;
    logic       plot_ready;
    logic       clear_req;
    logic [2:0] clear_colour;
    logic       busy;
    logic       mem_we;
    logic [14:0] mem_addr;
    logic [2:0] mem_data;
`ifdef FB_OOB_COUNT_EN
    logic [7:0] oob_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Expected writes in order, each encoded as addr*8 + colour.
    logic [31:0] exp_q[$];
    int          oob_exp = 0;

    fb_plot_sink dut (
        .clk          (clk),
        .r_set        (r_set),
        .plot_x       (plot_x),
        .plot_y       (plot_y),
        .plot_c       (plot_c),
        .plot_valid   (plot_valid),
        .plot_ready   (plot_ready),
        .clear_req    (clear_req),
        .clear_colour (clear_colour),
        .busy         (busy),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data)
`ifdef FB_OOB_COUNT_EN
        ,
        .oob_count    (oob_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_plot(input int x, input int y, input int c);
        if (x < 160 && y < 120) exp_q.push_back(32'((y * 160 + x) * 8 + c));
        else if (oob_exp < 255) oob_exp++;
    endtask

    task automatic model_clear(input int c);
        for (int a = 0; a < 160 * 120; a++) exp_q.push_back(32'(a * 8 + c));
    endtask

    // Write monitor: every observed write must be the next expected one.
    always @(negedge clk) begin
        if (r_set === 1'b0 && mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_write_qlen", 32'(exp_q.size() != 0), 32'd1);
            end else begin
                check("mem_write", 32'({mem_addr, mem_data}), exp_q.pop_front());
            end
        end
    end

    // Called just after a negedge; returns just after the negedge that follows
    // the accepting edge, with plot_valid still high.
    task automatic send(input int x, input int y, input int c,
                        input bit clr, input int clr_c, output int stalls);
        stalls     = 0;
        plot_x     = 8'(x);
        plot_y     = 7'(y);
        plot_c     = 3'(c);
        plot_valid = 1'b1;
        while (plot_ready !== 1'b1 && stalls < 25000) begin
            @(negedge clk);
            stalls++;
        end
        check("accept_ready", 32'(plot_ready), 32'd1);
        if (clr) begin
            clear_req    = 1'b1;
            clear_colour = 3'(clr_c);
        end
        model_plot(x, y, c);
        if (clr) model_clear(clr_c);
        @(negedge clk);
        clear_req = 1'b0;
    endtask

    task automatic do_clear(input int clr_c);
        clear_req    = 1'b1;
        clear_colour = 3'(clr_c);
        model_clear(clr_c);
        @(negedge clk);
        clear_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 25000; i++) begin
            if (exp_q.size() == 0 && busy === 1'b0 && mem_we === 1'b0) break;
            @(negedge clk);
        end
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int  st;
        int  st_sum;
        int  x;
        int  y;
        bit  found;

        r_set        = 1'b1;
        plot_x       = '0;
        plot_y       = '0;
        plot_c       = '0;
        plot_valid   = 1'b0;
        clear_req    = 1'b0;
        clear_colour = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_data", 32'(mem_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef FB_OOB_COUNT_EN
        check("rst_oob", 32'(oob_count), 32'd0);
`endif
        r_set = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(plot_ready), 32'd1);

        // Single plot: write appears two edges after acceptance.
        send(5, 3, 5, 1'b0, 0, st);
        plot_valid = 1'b0;
        check("lat_we_early", 32'(mem_we), 32'd0);
        @(negedge clk);
        check("lat_we", 32'(mem_we), 32'd1);
        check("lat_addr", 32'(mem_addr), 32'd485);
        check("lat_data", 32'(mem_data), 32'd5);
        @(negedge clk);
        check("lat_we_after", 32'(mem_we), 32'd0);
        check("lat_busy", 32'(busy), 32'd0);

        // 4x4 square at (10,20), back to back with no stalls.
        st_sum = 0;
        for (int r = 0; r < 4; r++) begin
            for (int col = 0; col < 4; col++) begin
                send(10 + col, 20 + r, (r * 4 + col) % 8, 1'b0, 0, st);
                st_sum += st;
            end
        end
        plot_valid = 1'b0;
        check("square_stalls", 32'(st_sum), 32'd0);
        wait_idle("square");

        // Burst of four with clear_req alongside the last: drain, then full sweep.
        send(1, 1, 1, 1'b0, 0, st);
        send(2, 1, 2, 1'b0, 0, st);
        send(3, 1, 3, 1'b0, 0, st);
        send(4, 1, 4, 1'b1, 6, st);
        plot_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) begin
                found = 1'b1;
                break;
            end
            check("clear_ready_low", 32'(plot_ready), 32'd0);
        end
        check("clear_done", 32'(found), 32'd1);
        wait_idle("clear");
        @(negedge clk);
        check("clear_ready_back", 32'(plot_ready), 32'd1);

        // Off-screen pixels are consumed without a write.
        send(160, 0, 1, 1'b0, 0, st);
        send(0, 120, 2, 1'b0, 0, st);
        plot_valid = 1'b0;
        wait_idle("oob2");
`ifdef FB_OOB_COUNT_EN
        check("oob_two", 32'(oob_count), 32'(oob_exp));
`endif
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) send($urandom_range(160, 255), $urandom_range(0, 127), 0, 1'b0, 0, st);
            else            send($urandom_range(0, 159), $urandom_range(120, 127), 0, 1'b0, 0, st);
        end
        plot_valid = 1'b0;
        wait_idle("oob300");
`ifdef FB_OOB_COUNT_EN
        check("oob_sat", 32'(oob_count), 32'd255);
`endif

        // Reset in the middle of a clear sweep.
        do_clear(3);
        found = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (mem_we === 1'b1 && mem_addr === 15'd5000) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_5000", 32'(found), 32'd1);
        #1;
        r_set = 1'b1;
        #1;
        exp_q.delete();
        oob_exp = 0;
        check("midrst_we", 32'(mem_we), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("midrst_we_held", 32'(mem_we), 32'd0);
        r_set = 1'b0;
        #1;
        check("midrst_ready", 32'(plot_ready), 32'd1);
`ifdef FB_OOB_COUNT_EN
        check("midrst_oob", 32'(oob_count), 32'd0);
`endif
        @(negedge clk);
        send(7, 9, 2, 1'b0, 0, st);
        plot_valid = 1'b0;
        wait_idle("post_rst");

        // Bottom-right corner is on screen.
        send(159, 119, 7, 1'b0, 0, st);
        plot_valid = 1'b0;
        wait_idle("corner");

        // Random plots with random gaps, some off screen.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                plot_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            x = $urandom_range(0, 175);
            y = $urandom_range(0, 127);
            send(x, y, $urandom_range(0, 7), 1'b0, 0, st);
        end
        plot_valid = 1'b0;
        wait_idle("random");
`ifdef FB_OOB_COUNT_EN
        check("random_oob", 32'(oob_count), 32'(oob_exp));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
